alu_arbiter: RTL and testbench

Sequencer that shares the single combinational `ALU` (8-bit opcode, two 32-bit operands, 32-bit result) between two requesters, such as the integer pipeline and a debug/CSR path. The arbiter accepts one operation at a time over a valid/ready handshake and grants requesters round-robin. It registers the operands, evaluates them through an internally instantiated `ALU`, and returns the registered result to the winning requester over a held response handshake. It also keeps a count of completed operations.

---
 rtl/alu_arbiter.sv | 143 ++++++++++++++
 tb/tb_alu_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered on accept, evaluated in EXEC and returned from a held response register.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic [OP_W-1:0]   req_opcode_0,
  input  logic [OP_W-1:0]   req_opcode_1,
  input  logic [DATA_W-1:0] req_imm1_0,
  input  logic [DATA_W-1:0] req_imm1_1,
  input  logic [DATA_W-1:0] req_imm2_0,
  input  logic [DATA_W-1:0] req_imm2_1,
  output logic              resp_valid_0,
  output logic              resp_valid_1,
  input  logic              resp_ready_0,
  input  logic              resp_ready_1,
  output logic [DATA_W-1:0] resp_result,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_next;
  logic              last_grant, owner_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q, b_q, res_q, alu_res;
  logic              any_valid, grant_sel, accept, resp_fire;

  // On a tie the requester that did not win last time is granted.
  assign any_valid = req_valid_0 | req_valid_1;
  assign grant_sel = (req_valid_0 & req_valid_1) ? ~last_grant : req_valid_1;
  assign accept    = (state == IDLE) && any_valid;
  assign resp_fire = (state == RESP) && (owner_q ? resp_ready_1 : resp_ready_0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_valid) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (resp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready is gated by rst so nothing is advertised while reset is held.
  always_comb begin
    req_ready_0  = 1'b0;
    req_ready_1  = 1'b0;
    resp_valid_0 = 1'b0;
    resp_valid_1 = 1'b0;
    busy         = (state != IDLE);
    if (!rst && state == IDLE && any_valid) begin
      req_ready_0 = ~grant_sel;
      req_ready_1 = grant_sel;
    end
    if (state == RESP) begin
      resp_valid_0 = ~owner_q;
      resp_valid_1 = owner_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        op_q       <= grant_sel ? req_opcode_1 : req_opcode_0;
        a_q        <= grant_sel ? req_imm1_1   : req_imm1_0;
        b_q        <= grant_sel ? req_imm2_1   : req_imm2_0;
        owner_q    <= grant_sel;
        last_grant <= grant_sel;
      end
      if (state == EXEC) res_q <= alu_res;
      if (resp_fire)     op_count <= op_count + CNT_W'(1);
    end
  end

  ALU #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .opcode (op_q),
    .imm1   (a_q),
    .imm2   (b_q),
    .result (alu_res)
  );

  assign resp_result = res_q;

endmodule

// Shared combinational ALU; results wrap to DATA_W bits with no carry out.
module ALU #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 8
) (
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] imm1,
  input  logic [DATA_W-1:0] imm2,
  output logic [DATA_W-1:0] result
);

  logic signed [DATA_W-1:0] sa, sb;
  logic [4:0]               shamt;

  assign sa    = imm1;
  assign sb    = imm2;
  assign shamt = imm2[4:0];

  always_comb begin
    result = '0;
    case (opcode)
      OP_W'(0): result = imm1 + imm2;
      OP_W'(1): result = imm1 - imm2;
      OP_W'(2): result = imm1 & imm2;
      OP_W'(3): result = imm1 | imm2;
      OP_W'(4): result = imm1 ^ imm2;
      OP_W'(5): result = imm1 << shamt;
      OP_W'(6): result = imm1 >> shamt;
      OP_W'(7): result = sa >>> shamt;
      OP_W'(8): result = {{(DATA_W-1){1'b0}}, (sa < sb)};
      OP_W'(9): result = {{(DATA_W-1){1'b0}}, (imm1 < imm2)};
      default:  result = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a second instance with a 4-bit counter shares the stimulus.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic [7:0]  req_opcode_0 = '0, req_opcode_1 = '0;
  logic [31:0] req_imm1_0 = '0, req_imm1_1 = '0, req_imm2_0 = '0, req_imm2_1 = '0;
  logic        resp_ready_0 = 1'b0, resp_ready_1 = 1'b0;

  logic        req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, busy;
  logic [31:0] resp_result;
  logic [15:0] op_count;

  logic        w_req_ready_0, w_req_ready_1, w_resp_valid_0, w_resp_valid_1, w_busy;
  logic [31:0] w_resp_result;
  logic [3:0]  w_op_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_opcode_0(req_opcode_0), .req_opcode_1(req_opcode_1),
    .req_imm1_0(req_imm1_0), .req_imm1_1(req_imm1_1),
    .req_imm2_0(req_imm2_0), .req_imm2_1(req_imm2_1),
    .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
    .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
    .resp_result(resp_result), .busy(busy), .op_count(op_count)
  );

  alu_arbiter #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(w_req_ready_0), .req_ready_1(w_req_ready_1),
    .req_opcode_0(req_opcode_0), .req_opcode_1(req_opcode_1),
    .req_imm1_0(req_imm1_0), .req_imm1_1(req_imm1_1),
    .req_imm2_0(req_imm2_0), .req_imm2_1(req_imm2_1),
    .resp_valid_0(w_resp_valid_0), .resp_valid_1(w_resp_valid_1),
    .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
    .resp_result(w_resp_result), .busy(w_busy), .op_count(w_op_count)
  );

  task automatic clear_inputs();
    req_valid_0 = 0; req_valid_1 = 0; resp_ready_0 = 0; resp_ready_1 = 0;
    req_opcode_0 = 0; req_opcode_1 = 0;
    req_imm1_0 = 0; req_imm1_1 = 0; req_imm2_0 = 0; req_imm2_1 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // Drives one operation on requester k with resp_ready held high; reports what it observed.
  task automatic run_op(input bit k, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit ok);
    bit got;
    ok = 0; lat = 0; res = 'x; got = 0;
    @(negedge clk);
    if (k) begin req_valid_1 = 1; req_opcode_1 = op; req_imm1_1 = a; req_imm2_1 = b; resp_ready_1 = 1; end
    else   begin req_valid_0 = 1; req_opcode_0 = op; req_imm1_0 = a; req_imm2_0 = b; resp_ready_0 = 1; end
    for (int t = 0; t < 20; t++) begin
      #1;
      if ((k ? req_ready_1 : req_ready_0) === 1'b1) begin got = 1; break; end
      @(negedge clk);
    end
    if (got) begin
      @(posedge clk); #1;
      req_valid_0 = 0; req_valid_1 = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk); lat++;
        if ((k ? resp_valid_1 : resp_valid_0) === 1'b1) begin ok = 1; res = resp_result; break; end
      end
      if (ok) begin @(posedge clk); #1; end
    end
    req_valid_0 = 0; req_valid_1 = 0; resp_ready_0 = 0; resp_ready_1 = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1;
    req_valid_0 = 1; req_valid_1 = 1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if ({req_ready_0, req_ready_1} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {req_ready_0, req_ready_1}); end
    checks++; if ({resp_valid_0, resp_valid_1} !== 2'b00) begin failures++; $display("FAIL reset_resp_valid got=%b exp=00", {resp_valid_0, resp_valid_1}); end
    checks++; if (op_count !== 16'd0) begin failures++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    checks++; if (resp_result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", resp_result); end
    do_reset();
  endtask

  task automatic test_single();
    logic [31:0] res; int lat; bit ok;
    do_reset();
    run_op(0, 8'd0, 32'd3, 32'd4, res, lat, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_handshake got=timeout exp=done"); end
    checks++; if (res !== 32'd7) begin failures++; $display("FAIL single_result got=%0d exp=7", res); end
    checks++; if (lat != 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", lat); end
    @(negedge clk);
    checks++; if (op_count !== 16'd1) begin failures++; $display("FAIL single_op_count got=%0d exp=1", op_count); end
  endtask

  task automatic test_sweep();
    logic [31:0] res; int lat; bit ok;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      run_op(0, 8'd0, i, i, res, lat, ok);
      checks++;
      if (!ok || res !== 32'(2 * i)) begin
        failures++; $display("FAIL sweep_%0d got=%h exp=%h ok=%0b", i, res, 32'(2 * i), ok);
      end
    end
    @(negedge clk);
    checks++; if (op_count !== 16'd32) begin failures++; $display("FAIL sweep_op_count got=%0d exp=32", op_count); end
  endtask

  task automatic test_tie();
    bit exp_k, got;
    logic [31:0] exp_res;
    do_reset();
    @(negedge clk);
    req_valid_0 = 1; req_imm1_0 = 1; req_imm2_0 = 1;
    req_valid_1 = 1; req_imm1_1 = 5; req_imm2_1 = 5;
    resp_ready_0 = 1; resp_ready_1 = 1;
    for (int n = 0; n < 3; n++) begin
      exp_k = (n == 1);
      exp_res = exp_k ? 32'd10 : 32'd2;
      got = 0;
      for (int t = 0; t < 20; t++) begin
        #1;
        if (req_ready_0 === 1'b1 || req_ready_1 === 1'b1) begin got = 1; break; end
        @(negedge clk);
      end
      checks++;
      if (!got || req_ready_0 !== !exp_k || req_ready_1 !== exp_k) begin
        failures++; $display("FAIL tie_grant_%0d got=%b exp=%b", n, {req_ready_1, req_ready_0}, exp_k ? 2'b10 : 2'b01);
      end
      @(posedge clk);
      got = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (resp_valid_0 === 1'b1 || resp_valid_1 === 1'b1) begin got = 1; break; end
      end
      checks++;
      if (!got || resp_valid_0 !== !exp_k || resp_valid_1 !== exp_k || resp_result !== exp_res) begin
        failures++; $display("FAIL tie_resp_%0d got=v%b r=%0d exp=v%b r=%0d", n, {resp_valid_1, resp_valid_0}, resp_result, exp_k ? 2'b10 : 2'b01, exp_res);
      end
      @(posedge clk); #1;
      if (n == 2) begin req_valid_0 = 0; req_valid_1 = 0; end
      @(negedge clk);
    end
    resp_ready_0 = 0; resp_ready_1 = 0;
  endtask

  task automatic test_backpressure();
    bit got;
    do_reset();
    @(negedge clk);
    req_valid_0 = 1; req_imm1_0 = 8; req_imm2_0 = 8; resp_ready_0 = 0;
    got = 0;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (req_ready_0 === 1'b1) begin got = 1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    for (int t = 0; t < 20 && got; t++) begin
      @(negedge clk);
      if (resp_valid_0 === 1'b1) break;
      if (t == 19) got = 0;
    end
    checks++; if (!got) begin failures++; $display("FAIL bp_resp_valid got=timeout exp=rise"); end
    resp_ready_1 = 1; req_valid_1 = 1;
    for (int c = 0; c < 5; c++) begin
      req_imm1_0 = 32'h100 + c; req_imm2_0 = 32'h200 + c;
      req_imm1_1 = 32'h300 + c; req_imm2_1 = 32'h400 + c;
      #1;
      checks++;
      if (resp_valid_0 !== 1'b1 || resp_valid_1 !== 1'b0 || resp_result !== 32'h10 ||
          req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold_%0d got=rv%b r=%h rr%b busy=%b exp=rv01 r=00000010 rr00 busy=1",
                 c, {resp_valid_1, resp_valid_0}, resp_result, {req_ready_1, req_ready_0}, busy);
      end
      @(negedge clk);
    end
    checks++; if (op_count !== 16'd0) begin failures++; $display("FAIL bp_count_held got=%0d exp=0", op_count); end
    req_valid_0 = 0; req_valid_1 = 0; resp_ready_1 = 0; resp_ready_0 = 1;
    @(negedge clk);
    resp_ready_0 = 0;
    checks++; if (op_count !== 16'd1 || busy !== 1'b0) begin failures++; $display("FAIL bp_release got=cnt%0d busy=%b exp=cnt1 busy=0", op_count, busy); end
  endtask

  task automatic test_reset_abort();
    bit got;
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      // Put requester 0 through one completed grant first so last_grant would otherwise favour 1.
      @(negedge clk);
      req_valid_0 = 1; req_imm1_0 = 2; req_imm2_0 = 2; resp_ready_0 = 0;
      @(posedge clk); #1;
      req_valid_0 = 0;
      @(negedge clk);
      if (phase == 1) @(negedge clk);
      got = (phase == 0) ? (busy === 1'b1 && resp_valid_0 === 1'b0) : (resp_valid_0 === 1'b1);
      checks++; if (!got) begin failures++; $display("FAIL abort_setup_%0d got=busy%b rv%b exp=state_reached", phase, busy, resp_valid_0); end
      #1;
      req_valid_0 = 1; req_valid_1 = 1; resp_ready_0 = 1;
      rst = 1;
      #1;
      checks++;
      if (busy !== 1'b0 || {resp_valid_0, resp_valid_1, req_ready_0, req_ready_1} !== 4'b0000 || op_count !== 16'd0) begin
        failures++;
        $display("FAIL abort_%0d got=busy%b rv%b rr%b cnt%0d exp=busy0 rv00 rr00 cnt0",
                 phase, busy, {resp_valid_1, resp_valid_0}, {req_ready_1, req_ready_0}, op_count);
      end
      @(negedge clk);
      rst = 0;
      #1;
      checks++;
      if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin
        failures++; $display("FAIL abort_tie_%0d got=%b exp=01", phase, {req_ready_1, req_ready_0});
      end
      @(negedge clk);
      clear_inputs();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] res; int lat; bit ok;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      if (i == 5) begin
        run_op(1, 8'd0, 32'hFFFF_FFFF, 32'd1, res, lat, ok);
        checks++; if (!ok || res !== 32'd0) begin failures++; $display("FAIL wrap_add_overflow got=%h exp=00000000 ok=%0b", res, ok); end
      end else begin
        run_op(i[0], 8'd0, i, 32'd1, res, lat, ok);
      end
    end
    @(negedge clk);
    checks++; if (w_op_count !== 4'd1) begin failures++; $display("FAIL wrap_count4 got=%0d exp=1", w_op_count); end
    checks++; if (op_count !== 16'd17) begin failures++; $display("FAIL wrap_count16 got=%0d exp=17", op_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_tie();
    test_backpressure();
    test_reset_abort();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=hung exp=finished");
    $fatal(1, "timeout");
  end

endmodule
